// File: rtl/hdr_pkg.sv
// rtl/hdr_pkg.sv - shared types and default resolution for the HDR merge sequencer and frame readers
package hdr_pkg;

    localparam int HDR_H_RES_DEF = 640;
    localparam int HDR_V_RES_DEF = 480;

    typedef enum logic [1:0] {
        HDR_IDLE  = 2'd0,
        HDR_RUN   = 2'd1,
        HDR_DRAIN = 2'd2,
        HDR_DONE  = 2'd3
    } hdr_state_e;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
        logic eof;
    } hdr_tag_t;

endpackage

// File: rtl/hdr_tag_pipe.sv
// rtl/hdr_tag_pipe.sv - free-running DEPTH-stage shift register carrying pixel tags beside the merge datapath
module hdr_tag_pipe
    import hdr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] tag_in,
    output logic [3:0] tag_out,
    output logic       empty
);

    hdr_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Empty means no pixel is still in flight through the datapath.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage[i].valid) begin
                empty = 1'b0;
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/hdr_merge_ctrl.sv
// rtl/hdr_merge_ctrl.sv - HDR merge sequencer: intake handshake, frame position, tags and credit throttle
// Optional stall counter output enabled by defining HDR_CTRL_STATS_EN.
module hdr_merge_ctrl
    import hdr_pkg::*;
#(
    parameter int H_RES    = HDR_H_RES_DEF,
    parameter int V_RES    = HDR_V_RES_DEF,
    parameter int PIPE_LAT = 4,
    parameter int CREDITS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        dp_start,
    output logic        res_valid,
    output logic        res_sof,
    output logic        res_eol,
    output logic        res_eof,
    input  logic        credit_ret,
    output logic        busy,
    output logic        frame_done,
    output logic        err
`ifdef HDR_CTRL_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int CRD_W = $clog2(CREDITS + 1);

    localparam logic [1:0] ST_IDLE  = HDR_IDLE;
    localparam logic [1:0] ST_RUN   = HDR_RUN;
    localparam logic [1:0] ST_DRAIN = HDR_DRAIN;
    localparam logic [1:0] ST_DONE  = HDR_DONE;

    logic [1:0]       state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CRD_W-1:0] credits;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             crd_full;
    logic             pipe_empty;
    logic             start_run;
    logic             err_set;
    hdr_tag_t         tag_d;
    hdr_tag_t         tag_q;

    assign busy       = (state != ST_IDLE);
    assign in_ready   = (state == ST_RUN) && (credits != '0);
    assign accept     = in_valid && in_ready;
    assign dp_start   = accept;
    assign frame_done = (state == ST_DONE);
    assign last_col   = (col == COL_W'(H_RES - 1));
    assign last_row   = (row == ROW_W'(V_RES - 1));
    assign crd_full   = (credits == CRD_W'(CREDITS));
    assign start_run  = (state == ST_IDLE) && frame_start;
    assign err_set    = (frame_start && busy) || (credit_ret && crd_full);

    always_comb begin
        tag_d = '0;
        if (accept) begin
            tag_d.valid = 1'b1;
            tag_d.sof   = (col == '0) && (row == '0);
            tag_d.eol   = last_col;
            tag_d.eof   = last_col && last_row;
        end
    end

    hdr_tag_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_d),
        .tag_out (tag_q),
        .empty   (pipe_empty)
    );

    assign res_valid = tag_q.valid;
    assign res_sof   = tag_q.sof;
    assign res_eol   = tag_q.eol;
    assign res_eof   = tag_q.eof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state <= ST_RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                            if (last_row) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Credits persist across frames; a return into a full count is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CRD_W'(CREDITS);
        end else if (accept && !credit_ret) begin
            credits <= credits - CRD_W'(1);
        end else if (!accept && credit_ret && !crd_full) begin
            credits <= credits + CRD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= (err && !start_run) || err_set;
        end
    end

`ifdef HDR_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_run) begin
            stall_cnt <= '0;
        end else if ((state == ST_RUN) && in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hdr_merge_ctrl.sv
// tb/tb_hdr_merge_ctrl.sv - self-checking bench for hdr_merge_ctrl on a 4x2 frame with tag scoreboard
module tb_hdr_merge_ctrl;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int LAT = 4;
    localparam int CRD = 8;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic in_valid = 1'b0;
    logic man_ret = 1'b0;
    logic auto_ret = 1'b0;
    logic credit_ret;
    logic in_ready, dp_start, res_valid, res_sof, res_eol, res_eof;
    logic busy, frame_done, err;
`ifdef HDR_CTRL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    assign credit_ret = man_ret | (auto_ret & res_valid);

    always #5 clk = ~clk;

    hdr_merge_ctrl #(
        .H_RES    (H),
        .V_RES    (V),
        .PIPE_LAT (LAT),
        .CREDITS  (CRD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dp_start    (dp_start),
        .res_valid   (res_valid),
        .res_sof     (res_sof),
        .res_eol     (res_eol),
        .res_eof     (res_eof),
        .credit_ret  (credit_ret),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
`ifdef HDR_CTRL_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        int   idx;
        logic sof;
        logic eol;
        logic eof;
    } vec_t;

    typedef struct {
        int   cyc;
        int   idx;
        logic sof;
        logic eol;
        logic eof;
    } exp_t;

    vec_t       tbl [NPIX];
    exp_t       sb [$];
    logic [3:0] res_log [NPIX];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_total = 0;
    int base = 0;
    int fd_cnt = 0;
    int last_res = -100;
    int first_acc = 0;
    int last_acc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Samples the current cycle at the falling edge, then steps past the next rising edge.
    task automatic tick();
        exp_t e;
        int   idx;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (in_valid || dp_start)
                check("dp_start_is_accept", int'(dp_start), int'(in_valid && in_ready));
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check("res_valid_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("res_latency", cyc - e.cyc, LAT);
                    check("res_sof", int'(res_sof), int'(e.sof));
                    check("res_eol", int'(res_eol), int'(e.eol));
                    check("res_eof", int'(res_eof), int'(e.eof));
                    res_log[e.idx] = {1'b1, res_sof, res_eol, res_eof};
                end
                last_res = cyc;
            end
            if (dp_start) begin
                idx = (acc_total - base) % NPIX;
                e.cyc = cyc;
                e.idx = idx;
                e.sof = (idx == 0);
                e.eol = ((idx % H) == H - 1);
                e.eof = (idx == NPIX - 1);
                sb.push_back(e);
                if (acc_total == base) first_acc = cyc;
                last_acc = cyc;
                acc_total++;
            end
            if (frame_done) begin
                fd_cnt++;
                check("frame_done_after_last_res", cyc - last_res, 2);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_frame();
        base = acc_total;
        for (int i = 0; i < NPIX; i++) res_log[i] = 4'd0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int s;
        s = fd_cnt;
        for (int i = 0; i < 300 && fd_cnt == s; i++) tick();
        check("frame_done_seen", fd_cnt - s, 1);
        tick();
        tick();
        check("frame_done_single", fd_cnt - s, 1);
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic check_table();
        for (int i = 0; i < NPIX; i++) begin
            check("tbl_flags", int'(res_log[tbl[i].idx]),
                  int'({1'b1, tbl[i].sof, tbl[i].eol, tbl[i].eof}));
        end
    endtask

    initial begin
        tbl[0] = '{0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{4, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{5, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{6, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{7, 1'b0, 1'b1, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        tick();

        // Frame A: returns follow results, accepts must be back-to-back
        auto_ret = 1'b1;
        in_valid = 1'b1;
        start_frame();
        check("busy_in_run", int'(busy), 1);
        check("ready_in_run", int'(in_ready), 1);
        wait_done();
        check("a_accepts", acc_total - base, NPIX);
        check("a_back_to_back", last_acc - first_acc, NPIX - 1);
        check("a_err", int'(err), 0);
        check_table();

        // Frame B: no returns, all credits consumed
        auto_ret = 1'b0;
        start_frame();
        wait_done();
        check("b_accepts", acc_total - base, NPIX);

        // Frame C: zero credits stalls intake
        start_frame();
        for (int i = 0; i < 6; i++) tick();
        check("c_stalled_accepts", acc_total - base, 0);
        check("c_stalled_ready", int'(in_ready), 0);
`ifdef HDR_CTRL_STATS_EN
        check("c_stall_cnt", int'(stall_cnt), 6);
`endif
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("c_one_credit_one_accept", acc_total - base, 1);
        check("c_ready_after_one", int'(in_ready), 0);
        in_valid = 1'b0;
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        check("c_ready_credit1", int'(in_ready), 1);
        in_valid = 1'b1;
        man_ret = 1'b1;
        tick();
        in_valid = 1'b0;
        man_ret = 1'b0;
        check("c_accept_with_ret", acc_total - base, 2);
        check("c_ready_kept", int'(in_ready), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("c_err_start_busy", int'(err), 1);
        check("c_still_busy", int'(busy), 1);
        auto_ret = 1'b1;
        in_valid = 1'b1;
        wait_done();
        check("c_accepts", acc_total - base, NPIX);
        check("c_err_sticky", int'(err), 1);

        // Frame D: err clears on start, async reset during row 1
        start_frame();
        check("d_err_cleared", int'(err), 0);
        for (int i = 0; i < 300 && (acc_total - base) < 5; i++) tick();
        check("d_reached_row1", acc_total - base, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("d_async_busy", int'(busy), 0);
        check("d_async_ready", int'(in_ready), 0);
        check("d_async_dp_start", int'(dp_start), 0);
        check("d_async_res_valid", int'(res_valid), 0);
        begin
            int s;
            s = fd_cnt;
            tick();
            tick();
            rst_n = 1'b1;
            in_valid = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            check("d_no_frame_done", fd_cnt - s, 0);
        end

        // Frame E: restored credits give a full back-to-back frame without returns
        auto_ret = 1'b0;
        in_valid = 1'b1;
        start_frame();
        wait_done();
        check("e_accepts", acc_total - base, NPIX);
        check("e_back_to_back", last_acc - first_acc, NPIX - 1);
        check("e_sb_empty", sb.size(), 0);
        check_table();
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
